// File: rtl/req_arbiter4_pkg.sv
// Shared definitions for the 4-requester arbiter: FSM state encoding,
// the "no owner" code and conversions between owner code and one-hot grant.
package req_arbiter4_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [2:0] NONE = 3'd0;

  // Owner code 1..4 to one-hot grant vector [4:1]; anything else is no grant.
  function automatic logic [4:1] code2oh(input logic [2:0] c);
    case (c)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0010;
      3'd3:    return 4'b0100;
      3'd4:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // One-hot grant vector [4:1] back to owner code; non one-hot maps to NONE.
  function automatic logic [2:0] oh2code(input logic [4:1] oh);
    case (oh)
      4'b0001: return 3'd1;
      4'b0010: return 3'd2;
      4'b0100: return 3'd3;
      4'b1000: return 3'd4;
      default: return NONE;
    endcase
  endfunction

endpackage

// File: rtl/req_arbiter4_pick.sv
// Combinational winner pick among eligible[4:1]. The search starts at index
// 'start' (1..4, 0 treated as 4) and descends cyclically, 4 following 1.
// Returns NONE when nothing is eligible.
module req_pick4
  import req_arbiter4_pkg::*;
(
  input  logic [4:1] eligible,
  input  logic [2:0] start,
  output logic [2:0] code
);

  logic [1:0] s0;
  logic [3:0] e0;
  logic [3:0] rot;
  logic [1:0] off;
  logic       hit;

  // Rotate so the starting index lands in the MSB, then priority-encode.
  always_comb begin
    s0  = start[1:0] - 2'd1;
    e0  = eligible;
    rot = {e0[s0], e0[s0 - 2'd1], e0[s0 - 2'd2], e0[s0 - 2'd3]};
    hit = 1'b1;
    off = 2'd0;
    casez (rot)
      4'b1???: off = 2'd0;
      4'b01??: off = 2'd1;
      4'b001?: off = 2'd2;
      4'b0001: off = 2'd3;
      default: hit = 1'b0;
    endcase
    code = hit ? ({1'b0, s0 - off} + 3'd1) : NONE;
  end

endmodule

// File: rtl/req_arbiter4.sv
// Sequential 4-requester arbiter with grant holding, a MAX_HOLD limit that
// forces release (and masks the revoked owner for the next pick) and a
// mandatory idle cycle between grants.
// Optional: define REQ_ARBITER4_RR_EN for round-robin priority starting
// below the previous winner; otherwise fixed priority 4 > 3 > 2 > 1.
module req_arbiter4
  import req_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:1] req,
  output logic [4:1] gnt,
  output logic [2:0] gcode,
  output logic       busy,
  output logic       timeout
);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:1]    mask, mask_n;
  logic [2:0]    gcode_n;
  logic          timeout_n;
  logic [4:1]    eligible;
  logic [4:1]    pick_in;
  logic [2:0]    pick_start;
  logic [2:0]    pick;
  logic          owner_req;

`ifdef REQ_ARBITER4_RR_EN
  logic [2:0]    last, last_n;

  // Search begins one index below the last winner, wrapping 1 -> 4.
  always_comb begin
    case (last)
      3'd2:    pick_start = 3'd1;
      3'd3:    pick_start = 3'd2;
      3'd4:    pick_start = 3'd3;
      default: pick_start = 3'd4;
    endcase
  end
`else
  assign pick_start = 3'd4;
`endif

  // A masked requester is only passed over when someone else is asking.
  assign eligible  = req & ~mask;
  assign pick_in   = (|eligible) ? eligible : req;
  assign owner_req = |(req & gnt);

  req_pick4 u_pick (
    .eligible (pick_in),
    .start    (pick_start),
    .code     (pick)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      mask    <= '0;
      gcode   <= NONE;
      gnt     <= '0;
      timeout <= 1'b0;
`ifdef REQ_ARBITER4_RR_EN
      last    <= NONE;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      mask    <= mask_n;
      gcode   <= gcode_n;
      gnt     <= code2oh(gcode_n);
      timeout <= timeout_n;
`ifdef REQ_ARBITER4_RR_EN
      last    <= last_n;
`endif
    end
  end

  // Next-state: grant from IDLE, hold, normal release or forced release.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    mask_n    = mask;
    gcode_n   = gcode;
    timeout_n = 1'b0;
`ifdef REQ_ARBITER4_RR_EN
    last_n    = last;
`endif
    case (state)
      IDLE: begin
        if (pick != NONE) begin
          state_n = GRANT;
          gcode_n = pick;
          cnt_n   = CW'(1);
          mask_n  = '0;
`ifdef REQ_ARBITER4_RR_EN
          last_n  = pick;
`endif
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_n = IDLE;
          gcode_n = NONE;
        end else if (cnt == CW'(MAX_HOLD)) begin
          state_n   = IDLE;
          gcode_n   = NONE;
          timeout_n = 1'b1;
          mask_n    = gnt;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gcode_n = NONE;
      end
    endcase
  end

  // Busy mirrors the GRANT state register.
  always_comb begin
    busy = (state == GRANT);
  end

endmodule

// File: tb/tb_req_arbiter4.sv
// Bench for req_arbiter4 (MAX_HOLD = 4). A cycle-level model tracks the
// owner, hold length, masked index and last winner as plain integers and is
// compared with the DUT on every falling edge; directed steps also check
// hand-computed literal values. Honors REQ_ARBITER4_RR_EN like the RTL.
module tb_req_arbiter4;

  localparam int MAXH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:1] req;
  logic [4:1] gnt;
  logic [2:0] gcode;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  req_arbiter4 #(.MAX_HOLD(MAXH), .CW(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .gnt     (gnt),
    .gcode   (gcode),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = 0;   // 0 = none, else owning index
  int m_len   = 0;   // cycles granted so far
  int m_mask  = 0;   // index passed over next pick (0 = none)
  int m_last  = 0;   // last winner
  bit m_to    = 0;
  bit m_valid = 0;

  function automatic int m_pick(input logic [4:1] r, input int mask_idx, input int last);
    logic [4:1] e;
    int s;
    int idx;
    e = r;
    if (mask_idx != 0) e[mask_idx] = 1'b0;
    if (e == 4'b0000) e = r;
    s = 4;
`ifdef REQ_ARBITER4_RR_EN
    if (last >= 2) s = last - 1;
`endif
    for (int k = 0; k < 4; k++) begin
      idx = ((s - 1 - k + 8) % 4) + 1;
      if (e[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [4:1] m_oh(input int c);
    logic [4:1] v;
    v = 4'b0000;
    if (c >= 1 && c <= 4) v[c] = 1'b1;
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_owner <= 0; m_len <= 0; m_mask <= 0; m_last <= 0; m_to <= 0; m_valid <= 1;
    end else if (m_owner == 0) begin
      m_to <= 0;
      if (m_pick(req, m_mask, m_last) != 0) begin
        m_owner <= m_pick(req, m_mask, m_last);
        m_last  <= m_pick(req, m_mask, m_last);
        m_len   <= 1;
        m_mask  <= 0;
      end
    end else begin
      m_to <= 0;
      if (!req[m_owner]) begin
        m_owner <= 0;
      end else if (m_len == MAXH) begin
        m_owner <= 0;
        m_to    <= 1;
        m_mask  <= m_owner;
      end else begin
        m_len <= m_len + 1;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_gnt", 8'(gnt), 8'(m_oh(m_owner)));
      chk("model_gcode", 8'(gcode), 8'(m_owner));
      chk("model_busy", 8'(busy), 8'(m_owner != 0));
      chk("model_timeout", 8'(timeout), 8'(m_to));
      chk("model_onehot", 8'($countones(gnt) <= 1), 8'd1);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq_exp [5];

  initial begin
`ifdef REQ_ARBITER4_RR_EN
    seq_exp = '{4, 3, 2, 1, 4};
`else
    seq_exp = '{4, 4, 4, 4, 4};
`endif
    reset = 1'b1;
    req   = 4'b1111;

    // Reset held with all requests asserted.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gcode", 8'(gcode), 8'd0);
      chk("rst_gnt", 8'(gnt), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_timeout", 8'(timeout), 8'd0);
    end
    reset = 1'b0;
    tick();
    chk("first_gcode", 8'(gcode), 8'd4);
    chk("first_gnt", 8'(gnt), 8'b1000);
    req = 4'b0000;
    tick();
    chk("release_gcode", 8'(gcode), 8'd0);

    // Priority among 3 and 2, then one idle cycle before 2.
    req = 4'b0110;
    tick();
    chk("pri_3", 8'(gcode), 8'd3);
    tick();
    chk("pri_3_hold", 8'(gcode), 8'd3);
    req = 4'b0010;
    tick();
    chk("pri_gap", 8'(gcode), 8'd0);
    chk("pri_gap_busy", 8'(busy), 8'd0);
    tick();
    chk("pri_2", 8'(gcode), 8'd2);
    req = 4'b0000;
    tick();
    chk("pri_idle", 8'(gcode), 8'd0);

    // Release latency: 3 request cycles give exactly 3 grant cycles.
    req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lat_gnt", 8'(gnt), 8'b0001);
    end
    req = 4'b0000;
    tick();
    chk("lat_release", 8'(gnt), 8'b0000);

    // Timeout: 4 beats for owner 4, pulse, gap, then 1 instead of 4.
    req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("to_owner4", 8'(gcode), 8'd4);
      chk("to_quiet", 8'(timeout), 8'd0);
    end
    tick();
    chk("to_pulse", 8'(timeout), 8'd1);
    chk("to_gap", 8'(gcode), 8'd0);
    tick();
    chk("to_next1", 8'(gcode), 8'd1);
    chk("to_pulse_end", 8'(timeout), 8'd0);
    req = 4'b0000;
    tick();
    chk("to_idle", 8'(gcode), 8'd0);

    // Lone requester repeatedly revoked and regranted.
    req = 4'b0010;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        tick();
        chk("lone_gcode", 8'(gcode), 8'd2);
      end
      tick();
      chk("lone_to", 8'(timeout), 8'd1);
      chk("lone_gap", 8'(gcode), 8'd0);
    end
    req = 4'b0000;
    tick();
    chk("lone_idle", 8'(gcode), 8'd0);

    // Reset mid-grant revokes without a timeout pulse.
    req = 4'b1000;
    tick();
    chk("mid_grant", 8'(gcode), 8'd4);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_gcode", 8'(gcode), 8'd0);
    chk("mid_rst_to", 8'(timeout), 8'd0);

    // All requesting, each owner releases after 2 cycles.
    reset = 1'b0;
    req   = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk("seq_owner", 8'(gcode), 8'(seq_exp[g]));
      tick();
      req = 4'b1111 & ~gnt;
      tick();
      chk("seq_release", 8'(gcode), 8'd0);
      req = 4'b1111;
    end
    req = 4'b0000;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/req_arbiter4.md
Name: req_arbiter4

Overview:
Sequential arbiter that shares one resource among 4 requesters, req[4:1].
It uses the same encoding as the team's 4-input priority encoder: code 0 means none, codes 1..4 name the winning index, and fixed priority favours the highest index.
It adds grant holding, a hold-time limit and a mandatory idle gap between grants.
It sits between requesting blocks and the shared datapath, driving its select code.

Parameters:
MAX_HOLD, 16, maximum consecutive GRANT cycles for one owner (legal range 2..255).
CW, 8, width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
req  input  [4:1]  request lines; a requester holds its line high for as long as it wants the resource
gnt  output  [4:1]  one-hot grant, registered; all zeros when idle
gcode  output  [2:0]  registered owner code: 0 = none, 1..4 = owner index
busy  output  1  high while in GRANT
timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD

Behaviour:
- Reset (synchronous, with reset high at a rising edge):
  - state = IDLE; gnt = 0; gcode = 0; busy = 0; timeout = 0; hold counter = 0; mask = 0.
  - Reset asserted mid-grant revokes the grant at that edge with no timeout pulse.
- IDLE state:
  - Compute eligible = req & ~mask.
  - If eligible != 0, the winner is the highest set index of eligible.
    - Next edge: state = GRANT, gnt = onehot(winner), gcode = winner, busy = 1, counter = 1.
  - If eligible = 0 but req != 0 (only the masked requester is asking), that requester is granted anyway.
  - mask is cleared on every IDLE-to-GRANT transition.
- GRANT state:
  - If req[owner] = 0 at an edge: state = IDLE, gnt/gcode/busy cleared at that edge. Normal release.
  - Else if counter == MAX_HOLD: state = IDLE, outputs cleared, timeout = 1 for exactly one cycle, mask = onehot(owner). Forced release.
  - Else: counter increments; outputs unchanged.
  - Requests from other indices are ignored while in GRANT; no preemption.
- Latency:
  - A request seen in IDLE at edge k gives gnt high after edge k.
  - Release seen at edge k gives gnt low after edge k.
  - At least one IDLE cycle always separates two grants, even back to back.
- The grant is never longer than MAX_HOLD cycles.
- gcode and gnt are always consistent, and at most one gnt bit is ever set.
- Simultaneous requests are resolved by fixed priority 4 > 3 > 2 > 1, subject to the mask and the optional feature below.
- A requester that drops req on the same edge as it would be granted is simply not granted; the arbiter does not register stale requests.

Optional Feature:
Macro: REQ_ARBITER4_RR_EN.
- Defined: round-robin priority.
  - Add a register last[2:0] (reset 0) that is updated with the winner on every grant.
  - Search order starts at index last-1 and descends cyclically: 4 after 1, wrapping.
  - With last = 0, the search starts from index 4, the same as fixed priority.
  - The mask still applies.
- Undefined: fixed highest-index priority as described above; last is not implemented.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE, GRANT;
  - the code-to-onehot and onehot-to-code constants;
  - NONE = 3'd0.
- One sub-module is natural: req_pick4.
  - Combinational pick of the winner code from eligible[4:1] plus start index.
  - Casez-style; returns 0 when there is no request.
- Counter and FSM stay in the top level.

Test Plan:
- Reset hold: assert reset for 3 cycles with req = 4'b1111 -> gnt = 0, gcode = 0, busy = 0 throughout; first grant appears after the first edge with reset low, giving gcode = 4.
- Priority: req = 4'b0110 held -> gcode = 3; drop req[3] -> one IDLE cycle (gcode = 0), then gcode = 2.
- Release latency: req = 4'b0001 for 5 cycles then 0 -> gnt = 4'b0001 for exactly 5 cycles, starting one edge after req rises.
- Timeout with MAX_HOLD = 4: req = 4'b1000 and 4'b0001 both held -> gcode = 4 for 4 cycles; timeout pulses once; IDLE for one cycle; gcode = 1 next, not 4.
- Lone timeout: only req[2] held, MAX_HOLD = 4 -> grants of 4 cycles repeat, separated by one IDLE cycle, with a timeout pulse before each gap.
- RR (macro defined): req = 4'b1111 held, each grant released after 2 cycles -> gcode sequence 4, 3, 2, 1, 4.
